gsm_cmd_sched: RTL



---
 rtl/gsm_cmd_pkg.sv | 48 ++++
 rtl/gsm_cmd_rom.sv | 46 ++++
 rtl/gsm_cmd_sched.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/gsm_cmd_pkg.sv
// gsm_cmd_pkg: shared definitions for the GSM AT-command scheduler.
//   - command IDs (CMD_AT .. CMD_ATH, CMD_INVALID)
//   - FSM state encoding
//   - ASCII CR terminator
//   - per-command byte lengths, plus a helper returning the length by ID
// Optional watchdog in the scheduler is enabled with GSM_CMD_SCHED_WDOG_EN.
package gsm_cmd_pkg;

    localparam logic [2:0] CMD_AT      = 3'd0;
    localparam logic [2:0] CMD_CPIN    = 3'd1;
    localparam logic [2:0] CMD_CSQ     = 3'd2;
    localparam logic [2:0] CMD_CREG    = 3'd3;
    localparam logic [2:0] CMD_CGATT   = 3'd4;
    localparam logic [2:0] CMD_ATD     = 3'd5;
    localparam logic [2:0] CMD_ATH     = 3'd6;
    localparam logic [2:0] CMD_INVALID = 3'd7;

    localparam logic [7:0] ASCII_CR = 8'h0D;

    // "ATD" + 11 digits + ";" + CR = 16 bytes, the largest entry; fits a 4-bit index.
    localparam logic [4:0] LEN_AT    = 5'd3;
    localparam logic [4:0] LEN_CPIN  = 5'd9;
    localparam logic [4:0] LEN_CSQ   = 5'd7;
    localparam logic [4:0] LEN_CREG  = 5'd9;
    localparam logic [4:0] LEN_CGATT = 5'd10;
    localparam logic [4:0] LEN_ATD   = 5'd16;
    localparam logic [4:0] LEN_ATH   = 5'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    function automatic logic [4:0] cmd_len(input logic [2:0] cmd);
        case (cmd)
            CMD_AT:    cmd_len = LEN_AT;
            CMD_CPIN:  cmd_len = LEN_CPIN;
            CMD_CSQ:   cmd_len = LEN_CSQ;
            CMD_CREG:  cmd_len = LEN_CREG;
            CMD_CGATT: cmd_len = LEN_CGATT;
            CMD_ATD:   cmd_len = LEN_ATD;
            CMD_ATH:   cmd_len = LEN_ATH;
            default:   cmd_len = 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/gsm_cmd_rom.sv
// gsm_cmd_rom: combinational command table.
// Ports:
//   cmd       in  3   command ID
//   idx       in  4   byte index within the command
//   telephone in  88  11 ASCII digits for the dial command, first digit in MSB byte
//   data      out 8   byte at idx (0 when idx is past the end or ID is invalid)
//   last      out 1   idx addresses the final byte of the command
module gsm_cmd_rom
    import gsm_cmd_pkg::*;
(
    input  logic [2:0]  cmd,
    input  logic [3:0]  idx,
    input  logic [87:0] telephone,
    output logic [7:0]  data,
    output logic        last
);

    // Each command string is right-justified in str so byte idx sits at
    // position (len-1-idx) counting bytes from the LSB.
    logic [127:0] str;
    logic [4:0]   len;
    logic [3:0]   pos;

    always_comb begin
        str = '0;
        len = cmd_len(cmd);
        case (cmd)
            CMD_AT:    str[23:0]  = {"AT", ASCII_CR};
            CMD_CPIN:  str[71:0]  = {"AT+CPIN?", ASCII_CR};
            CMD_CSQ:   str[55:0]  = {"AT+CSQ", ASCII_CR};
            CMD_CREG:  str[71:0]  = {"AT+CREG?", ASCII_CR};
            CMD_CGATT: str[79:0]  = {"AT+CGATT?", ASCII_CR};
            CMD_ATD:   str        = {"ATD", telephone, ";", ASCII_CR};
            CMD_ATH:   str[31:0]  = {"ATH", ASCII_CR};
            default:   str        = '0;
        endcase
        pos  = 4'(len - 5'd1 - {1'b0, idx});
        data = 8'h00;
        last = 1'b0;
        if ({1'b0, idx} < len) begin
            data = str[{pos, 3'b000} +: 8];
            last = ({1'b0, idx} == (len - 5'd1));
        end
    end

endmodule

// File: rtl/gsm_cmd_sched.sv
// gsm_cmd_sched: round-robin scheduler sharing one UART byte transmitter
// between NREQ requesters, each asking for a GSM AT command by ID.
// Optional stall watchdog on tx_ready: define GSM_CMD_SCHED_WDOG_EN.
// Ports:
//   clk        in  1        system clock
//   rst_n      in  1        asynchronous active-low reset
//   req        in  NREQ     level request per requester, held until its done
//   req_cmd    in  3*NREQ   command ID, requester i in [3i+2:3i]
//   telephone  in  88       dial digits, latched at grant
//   tx_data    out 8        byte to serializer
//   tx_valid   out 1        tx_data valid
//   tx_ready   in  1        serializer accepts on tx_valid && tx_ready
//   done       out NREQ     one-cycle completion pulse to granted requester
//   err        out 1        one-cycle pulse: invalid ID or watchdog abort
//   busy       out 1        high outside IDLE
//   gnt_id     out 3        current/last granted requester
//
// state | meaning
// IDLE  | arbitrate; also reports an invalid-ID grant one cycle later
// SEND  | stream command bytes on the valid/ready interface
// GAP   | guard delay after the final byte before done
module gsm_cmd_sched
    import gsm_cmd_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int GAP_CYCLES  = 12000000,
    parameter int WDOG_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [3*NREQ-1:0] req_cmd,
    input  logic [87:0]       telephone,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [NREQ-1:0]   done,
    output logic              err,
    output logic              busy,
    output logic [2:0]        gnt_id
);

    if (NREQ < 2 || NREQ > 8 || GAP_CYCLES < 1 || WDOG_CYCLES < 1) begin : g_param_check
        $error("gsm_cmd_sched: parameter out of range");
    end

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0]   GAP_LAST = GW'(GAP_CYCLES - 1);
    localparam logic [NREQ-1:0] DONE_ONE = {{(NREQ-1){1'b0}}, 1'b1};

`ifdef GSM_CMD_SCHED_WDOG_EN
    localparam int WW = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
    localparam logic [WW-1:0] WDOG_LAST = WW'(WDOG_CYCLES - 1);
    logic [WW-1:0] wdog_cnt;
`endif

    state_t        state;
    logic [2:0]    cmd_q;
    logic [87:0]   tel_q;
    logic [3:0]    idx;
    logic          last_q;
    logic          inv_pend;
    logic [GW-1:0] gap_cnt;

    logic [7:0]        rom_byte;
    logic              rom_last;
    logic [2:0]        gnt_nxt;
    logic [2:0]        sel_cmd;
    logic              req_any;
    int                cand;
    logic [NREQ-1:0]   req_rot;
    logic [3*NREQ-1:0] cmd_rot;

    // idx always points at the next byte to load into tx_data.
    gsm_cmd_rom u_rom (
        .cmd       (cmd_q),
        .idx       (idx),
        .telephone (tel_q),
        .data      (rom_byte),
        .last      (rom_last)
    );

    // Search from gnt_id+1 upward with wrap; walking k downward lets the
    // closest candidate overwrite the farther ones.
    always_comb begin
        gnt_nxt = gnt_id;
        req_any = 1'b0;
        cand    = 0;
        req_rot = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand    = (int'(gnt_id) + k) % NREQ;
            req_rot = req >> cand;
            if (req_rot[0]) begin
                gnt_nxt = 3'(cand);
                req_any = 1'b1;
            end
        end
        cmd_rot = req_cmd >> (3 * int'(gnt_nxt));
        sel_cmd = cmd_rot[2:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            tx_data  <= 8'h00;
            tx_valid <= 1'b0;
            done     <= '0;
            err      <= 1'b0;
            busy     <= 1'b0;
            gnt_id   <= 3'(NREQ - 1);
            cmd_q    <= CMD_AT;
            tel_q    <= '0;
            idx      <= 4'd0;
            last_q   <= 1'b0;
            inv_pend <= 1'b0;
            gap_cnt  <= '0;
`ifdef GSM_CMD_SCHED_WDOG_EN
            wdog_cnt <= '0;
`endif
        end else begin
            done <= '0;
            err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (inv_pend) begin
                        inv_pend <= 1'b0;
                        err      <= 1'b1;
                        done     <= DONE_ONE << gnt_id;
                    end else if (req_any && (done == '0)) begin
                        // Holding off while done is high gives the finished
                        // requester one cycle to drop req before re-arbitration.
                        gnt_id <= gnt_nxt;
                        cmd_q  <= sel_cmd;
                        tel_q  <= telephone;
                        idx    <= 4'd0;
                        if (sel_cmd == CMD_INVALID) begin
                            inv_pend <= 1'b1;
                        end else begin
                            state <= ST_SEND;
                            busy  <= 1'b1;
                        end
                    end
                end
                ST_SEND: begin
                    if (!tx_valid || (tx_ready && !last_q)) begin
                        tx_valid <= 1'b1;
                        tx_data  <= rom_byte;
                        last_q   <= rom_last;
                        idx      <= idx + 4'd1;
`ifdef GSM_CMD_SCHED_WDOG_EN
                        wdog_cnt <= '0;
`endif
                    end else if (tx_ready) begin
                        tx_valid <= 1'b0;
                        gap_cnt  <= '0;
                        state    <= ST_GAP;
                    end
`ifdef GSM_CMD_SCHED_WDOG_EN
                    else if (wdog_cnt == WDOG_LAST) begin
                        tx_valid <= 1'b0;
                        err      <= 1'b1;
                        done     <= DONE_ONE << gnt_id;
                        busy     <= 1'b0;
                        state    <= ST_IDLE;
                    end else begin
                        wdog_cnt <= wdog_cnt + WW'(1);
                    end
`endif
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        done  <= DONE_ONE << gnt_id;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
